// File: rtl/man_rx_phy_kb_pkg.sv
// Shared KB link definitions: FSM states, frame geometry, bit period and CRC constants.
package man_rx_phy_kb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC_LO,
        ST_DATA,
        ST_CRC_RX,
        ST_DONE
    } state_t;

    localparam int unsigned KB_WORDS       = 10;
    localparam int unsigned KB_CLK_PER_BIT = 40;
    localparam logic [15:0] CRC_POLY       = 16'h1021;
    localparam logic [15:0] CRC_INIT       = 16'hFFFF;

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic d);
        logic [15:0] n;
        n = {c[14:0], 1'b0};
        if (c[15] ^ d) begin
            n = n ^ CRC_POLY;
        end
        return n;
    endfunction

endpackage

// File: rtl/man_rx_phy_kb_crc16_ccitt_ser.sv
// Bit-serial CRC-16-CCITT (MSB first, no reflection, no final xor).
module crc16_ccitt_ser
    import man_rx_phy_kb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic [15:0] r_crc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_crc <= CRC_INIT;
        end else if (init) begin
            r_crc <= CRC_INIT;
        end else if (en) begin
            r_crc <= crc16_step(r_crc, din);
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/man_rx_phy_kb.sv
// KB link Manchester decoder: sync/filter the line, lock on the frame sync,
// recover data words, check the CRC and keep link-health counters.
module man_rx_phy_kb
    import man_rx_phy_kb_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = KB_CLK_PER_BIT,
    parameter int unsigned WORDS       = KB_WORDS,
    parameter int unsigned IDLE_BITS   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_d,
    output logic [15:0] word_data,
    output logic        word_valid,
    output logic [3:0]  word_idx,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);

    localparam int unsigned B  = CLK_PER_BIT;
    localparam int unsigned Q  = B / 4;
    localparam int unsigned TW = $clog2(3 * B);
    localparam int unsigned IW = $clog2(IDLE_BITS * B + 1);

    localparam logic [TW-1:0] T_SYNC_MIN = TW'(B + Q);
    localparam logic [TW-1:0] T_SYNC_MAX = TW'(2 * B - Q);
    localparam logic [TW-1:0] T_F_MIN    = TW'(2 * B - Q);
    localparam logic [TW-1:0] T_F_MAX    = TW'(2 * B + Q);
    localparam logic [TW-1:0] T_MIN      = TW'(B - Q);
    localparam logic [TW-1:0] T_MAX      = TW'(B + Q);
    localparam logic [IW-1:0] IDLE_LEN   = IW'(IDLE_BITS * B);
    localparam logic [3:0]    LAST_WORD  = 4'(WORDS - 1);

    state_t        r_state, w_next;
    logic [1:0]    r_sync;
    logic [2:0]    r_flt;
    logic          r_line, r_line_q;
    logic [TW-1:0] r_tcnt;
    logic [IW-1:0] r_idle_cnt;
    logic [3:0]    r_bitcnt, r_wcnt;
    logic          r_first;
    logic [15:0]   r_shift;
    logic [15:0]   r_word_data, r_frame_cnt, r_err_cnt;
    logic [3:0]    r_word_idx;
    logic          r_word_valid, r_frame_done, r_frame_ok;

    logic          w_rise, w_fall, w_edge, w_bit, w_idle_ok;
    logic          w_sync_start, w_lock, w_bit_en, w_err, w_word_end, w_crc_end, w_crc_en;
    logic [TW-1:0] w_win_lo, w_win_hi;
    logic [15:0]   w_rx_word, w_crc;

    // Line level after the mid-bit edge is the inverted bit value.
    assign w_rise    = r_line & ~r_line_q;
    assign w_fall    = ~r_line & r_line_q;
    assign w_edge    = w_rise | w_fall;
    assign w_bit     = ~r_line;
    assign w_idle_ok = (r_idle_cnt == IDLE_LEN);
    assign w_rx_word = {r_shift[14:0], w_bit};
    assign w_crc_en  = w_bit_en && (r_state == ST_DATA);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync   <= '1;
            r_flt    <= '1;
            r_line   <= 1'b1;
            r_line_q <= 1'b1;
        end else begin
            r_sync   <= {r_sync[0], rx_d};
            r_flt    <= {r_flt[1:0], r_sync[1]};
            r_line   <= (r_flt[0] & r_flt[1]) | (r_flt[0] & r_flt[2]) | (r_flt[1] & r_flt[2]);
            r_line_q <= r_line;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_sync_start = 1'b0;
        w_lock       = 1'b0;
        w_bit_en     = 1'b0;
        w_err        = 1'b0;
        w_word_end   = 1'b0;
        w_crc_end    = 1'b0;
        w_win_lo     = r_first ? T_F_MIN : T_MIN;
        w_win_hi     = r_first ? T_F_MAX : T_MAX;
        unique case (r_state)
            ST_IDLE: begin
                if (w_fall && w_idle_ok) begin
                    w_next       = ST_SYNC_LO;
                    w_sync_start = 1'b1;
                end
            end
            ST_SYNC_LO: begin
                if (w_rise && (r_tcnt >= T_SYNC_MIN) && (r_tcnt <= T_SYNC_MAX)) begin
                    w_next = ST_DATA;
                    w_lock = 1'b1;
                end else if (w_edge || (r_tcnt > T_SYNC_MAX)) begin
                    w_next = ST_IDLE;
                    w_err  = 1'b1;
                end
            end
            ST_DATA, ST_CRC_RX: begin
                // Edges before the window are bit-boundary transitions.
                if (w_edge && (r_tcnt >= w_win_lo) && (r_tcnt <= w_win_hi)) begin
                    w_bit_en = 1'b1;
                    if (r_bitcnt == 4'd15) begin
                        if (r_state == ST_DATA) begin
                            w_word_end = 1'b1;
                            if (r_wcnt == LAST_WORD) begin
                                w_next = ST_CRC_RX;
                            end
                        end else begin
                            w_crc_end = 1'b1;
                            w_next    = ST_DONE;
                        end
                    end
                end else if (r_tcnt > w_win_hi) begin
                    w_next = ST_IDLE;
                    w_err  = 1'b1;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tcnt     <= '0;
            r_idle_cnt <= '0;
            r_bitcnt   <= '0;
            r_wcnt     <= '0;
            r_first    <= 1'b0;
            r_shift    <= '0;
        end else begin
            if ((r_state != ST_IDLE) || !r_line) begin
                r_idle_cnt <= '0;
            end else if (!w_idle_ok) begin
                r_idle_cnt <= r_idle_cnt + IW'(1);
            end
            if (w_sync_start || w_lock || w_bit_en) begin
                r_tcnt <= '0;
            end else if (r_tcnt != '1) begin
                r_tcnt <= r_tcnt + TW'(1);
            end
            if (w_sync_start) begin
                r_wcnt <= '0;
            end else if (w_word_end) begin
                r_wcnt <= r_wcnt + 4'd1;
            end
            if (w_lock) begin
                r_bitcnt <= '0;
                r_first  <= 1'b1;
            end else if (w_bit_en) begin
                r_bitcnt <= r_bitcnt + 4'd1;
                r_first  <= 1'b0;
                r_shift  <= w_rx_word;
            end
        end
    end

    crc16_ccitt_ser u_crc (
        .clk   (clk),
        .reset (reset),
        .init  (w_sync_start),
        .en    (w_crc_en),
        .din   (w_bit),
        .crc   (w_crc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word_data  <= '0;
            r_word_valid <= 1'b0;
            r_word_idx   <= '0;
            r_frame_done <= 1'b0;
            r_frame_ok   <= 1'b0;
            r_frame_cnt  <= '0;
            r_err_cnt    <= '0;
        end else begin
            r_word_valid <= w_word_end;
            r_frame_done <= w_crc_end;
            if (w_sync_start) begin
                r_word_idx <= '0;
            end else if (w_word_end) begin
                r_word_idx <= r_wcnt;
            end
            if (w_word_end) begin
                r_word_data <= w_rx_word;
            end
            if (w_crc_end) begin
                r_frame_ok <= (w_crc == w_rx_word);
            end
            if (r_state == ST_DONE) begin
                if (r_frame_ok) begin
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end else if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + 16'd1;
                end
            end else if (w_err && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign word_data  = r_word_data;
    assign word_valid = r_word_valid;
    assign word_idx   = r_word_idx;
    assign frame_done = r_frame_done;
    assign frame_ok   = r_frame_ok;
    assign frame_cnt  = r_frame_cnt;
    assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_man_rx_phy_kb.sv
// Scoreboard bench for man_rx_phy_kb: directed Manchester frames with faults.
module tb_man_rx_phy_kb;

    localparam int B = 40;
    localparam int H = B / 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_d = 1'b1;
    logic [15:0] word_data;
    logic        word_valid;
    logic [3:0]  word_idx;
    logic        frame_done;
    logic        frame_ok;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;

    man_rx_phy_kb #(.CLK_PER_BIT(40), .WORDS(10), .IDLE_BITS(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_d       (rx_d),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_idx   (word_idx),
        .frame_done (frame_done),
        .frame_ok   (frame_ok),
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_frame;
        logic [3:0]  idx;
        logic [15:0] data;
        logic        ok;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cur_word = -1;
    logic [15:0] wd[10];
    logic [15:0] exp_frames = '0;
    logic [15:0] exp_errs = '0;

    function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
        logic [15:0] n;
        n = {c[14:0], 1'b0};
        if (c[15] ^ b) n = n ^ 16'h1021;
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic lvl, input int n);
        rx_d = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_word_data"},  32'(word_data),  32'h0);
        chk({tag, "_word_valid"}, 32'(word_valid), 32'h0);
        chk({tag, "_word_idx"},   32'(word_idx),   32'h0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'h0);
        chk({tag, "_frame_ok"},   32'(frame_ok),   32'h0);
        chk({tag, "_frame_cnt"},  32'(frame_cnt),  32'h0);
        chk({tag, "_err_cnt"},    32'(err_cnt),    32'h0);
    endtask

    task automatic settle_chk(input string tag);
        repeat (10) @(negedge clk);
        chk({tag, "_sb_empty"},  32'(sb.size()), 32'h0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
        chk({tag, "_err_cnt"},   32'(err_cnt),   32'(exp_errs));
    endtask

    // Half-bit lengths are per bit so jitter and late mid-edges can be injected.
    task automatic send_frame(input logic [15:0] crc_flip, input int drop_bit, input int late_bit,
                              input bit jitter, input int n_words, input bit done_exp, input bit ok_exp);
        logic        bits[176];
        logic [15:0] c;
        int          a_len;
        int          b_len;
        exp_t        e;
        c = 16'hFFFF;
        for (int w = 0; w < 10; w++) begin
            for (int i = 15; i >= 0; i--) begin
                bits[w*16 + 15 - i] = wd[w][i];
                c = crc_bit(c, wd[w][i]);
            end
        end
        c = c ^ crc_flip;
        for (int i = 15; i >= 0; i--) bits[160 + 15 - i] = c[i];
        hold(1'b1, 3*B);
        hold(1'b0, B + H);
        hold(1'b1, B + H);
        for (int k = 0; k < 176; k++) begin
            if (k % 16 == 0) begin
                cur_word = k / 16;
                if (k < 160 && cur_word < n_words) begin
                    e.is_frame = 1'b0; e.idx = 4'(cur_word); e.data = wd[cur_word]; e.ok = 1'b0;
                    sb.push_back(e);
                end
                if (k == 160 && done_exp) begin
                    e.is_frame = 1'b1; e.idx = 4'h0; e.data = 16'h0; e.ok = ok_exp;
                    sb.push_back(e);
                end
            end
            a_len = H;
            b_len = H;
            if (jitter) b_len = (k % 2 == 0) ? H + 8 : H - 8;
            if (k == late_bit) a_len = H + 12;
            if (k == drop_bit) begin
                hold(bits[k], a_len + b_len);
            end else begin
                hold(bits[k], a_len);
                hold(~bits[k], b_len);
            end
        end
        cur_word = -1;
        hold(1'b1, 2*B);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (word_valid || frame_done) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_strobe: word_valid=%0b idx=%0d data=%0h frame_done=%0b, expected no strobe",
                             word_valid, word_idx, word_data, frame_done);
                end else begin
                    e = sb.pop_front();
                    if (word_valid) begin
                        if (e.is_frame || word_idx !== e.idx || word_data !== e.data) begin
                            n_bad++;
                            $display("FAIL word: got idx=%0d data=%0h, expected frame=%0b idx=%0d data=%0h",
                                     word_idx, word_data, e.is_frame, e.idx, e.data);
                        end
                    end else if (!e.is_frame || frame_ok !== e.ok) begin
                        n_bad++;
                        $display("FAIL frame_done: got frame_ok=%0b, expected frame=%0b ok=%0b",
                                 frame_ok, e.is_frame, e.ok);
                    end
                end
            end
        end
    end

    initial begin : stim
        for (int i = 0; i < 10; i++) wd[i] = 16'(i + 1);
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        repeat (5) @(negedge clk);

        send_frame(16'h0000, -1, -1, 1'b0, 10, 1'b1, 1'b1);
        exp_frames = 16'd1;
        settle_chk("good");
        chk("good_frame_ok", 32'(frame_ok), 32'h1);

        send_frame(16'h0001, -1, -1, 1'b0, 10, 1'b1, 1'b0);
        exp_errs = 16'd1;
        settle_chk("crc_flip");

        send_frame(16'h0000, 56, -1, 1'b0, 3, 1'b0, 1'b0);
        exp_errs = 16'd2;
        settle_chk("drop_edge");
        chk("drop_frame_ok_held", 32'(frame_ok), 32'h0);

        send_frame(16'h0000, -1, -1, 1'b0, 10, 1'b1, 1'b1);
        exp_frames = 16'd2;
        settle_chk("good_after_drop");

        hold(1'b1, 3*B);
        hold(1'b0, B);
        hold(1'b1, 3*B);
        exp_errs = 16'd3;
        settle_chk("short_sync");

        hold(1'b1, 3*B);
        hold(1'b0, 1);
        hold(1'b1, 3*B);
        settle_chk("glitch");

        send_frame(16'h0000, -1, -1, 1'b1, 10, 1'b1, 1'b1);
        exp_frames = 16'd3;
        settle_chk("jitter8");

        send_frame(16'h0000, -1, 50, 1'b0, 3, 1'b0, 1'b0);
        exp_errs = 16'd4;
        settle_chk("late12");

        fork
            send_frame(16'h0000, -1, -1, 1'b0, 5, 1'b0, 1'b0);
            begin
                wait (cur_word == 5);
                repeat (200) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                check_zero("mid_reset");
                repeat (2) @(negedge clk);
                reset = 1'b0;
            end
        join
        exp_frames = 16'd0;
        exp_errs   = 16'd0;
        settle_chk("after_reset");

        send_frame(16'h0000, -1, -1, 1'b0, 10, 1'b1, 1'b1);
        exp_frames = 16'd1;
        settle_chk("good_after_reset");
        chk("final_frame_ok", 32'(frame_ok), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
